// File: rtl/ibex_pkg.sv
// Shared types and constants for the instruction prefetch slice.
// IBEX_PREFETCH_FETCH_ERR_EN adds a per-entry bus error bit to the fetch buffer.
package ibex_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StReq
    } prefetch_state_e;

    localparam logic [31:0] FETCH_INCR = 32'd4;

    typedef struct packed {
`ifdef IBEX_PREFETCH_FETCH_ERR_EN
        logic        err;
`endif
        logic [31:0] pc;
        logic [31:0] rdata;
    } fetch_entry_t;

    // Wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_fetch_addr(input logic [31:0] addr);
        return addr + FETCH_INCR;
    endfunction

endpackage

// File: rtl/ibex_fetch_fifo.sv
// Circular instruction buffer holding fetched words with their PC (and error bit when enabled).
// Flush wins over push and pop; a push into a full buffer is accepted only with a same-cycle pop.
module ibex_fetch_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_next_o,
    output fetch_entry_t     head_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    fetch_entry_t     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_ok && !flush_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    assign count_next_o = count_d;
    assign head_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/ibex_if_prefetch.sv
// Instruction prefetcher: issues word fetches, tracks outstanding responses and buffers them for ID.
// IBEX_PREFETCH_FETCH_ERR_EN forwards the bus error of the head entry on instr_fetch_err_o.
module ibex_if_prefetch
    import ibex_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] boot_addr_i,
    input  logic        pc_set_i,
    input  logic [31:0] branch_target_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        instr_valid_id_o,
    output logic        instr_new_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] pc_id_o,
    output logic        instr_fetch_err_o,
    input  logic        id_in_ready_i,
    input  logic        instr_valid_clear_i,
    output logic        busy_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    prefetch_state_e  state_q, state_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      rsp_addr_q, rsp_addr_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] discard_q, discard_d;
    logic             presented_q, presented_d;

    logic             gnt_fire, rsp_fire, rsp_drop, push, pop, issue_next;
    logic [CNT_W-1:0] count_next;
    logic             fifo_empty, unused_fifo_full;
    fetch_entry_t     push_entry, head;

    assign gnt_fire = instr_req_o & instr_gnt_i;
    // Responses with nothing outstanding belong to requests issued before a reset.
    assign rsp_fire = instr_rvalid_i & (outstanding_q != '0);
    assign rsp_drop = rsp_fire & (discard_q != '0);
    assign push     = rsp_fire & ~rsp_drop & ~pc_set_i;
    assign pop      = instr_valid_id_o & (id_in_ready_i | instr_valid_clear_i);

    always_comb begin
        push_entry       = '0;
        push_entry.rdata = instr_rdata_i;
        push_entry.pc    = rsp_addr_q;
`ifdef IBEX_PREFETCH_FETCH_ERR_EN
        push_entry.err   = instr_err_i;
`endif
    end

    ibex_fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (pc_set_i),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (pop),
        .full_o      (unused_fifo_full),
        .empty_o     (fifo_empty),
        .count_next_o(count_next),
        .head_o      (head)
    );

    always_comb begin
        outstanding_d = outstanding_q + OUT_W'(gnt_fire) - OUT_W'(rsp_fire);
        discard_d     = discard_q;
        if (pc_set_i) begin
            discard_d = outstanding_d;
        end else if (rsp_drop) begin
            discard_d = discard_q - OUT_W'(1);
        end

        fetch_addr_d = fetch_addr_q;
        if (pc_set_i) begin
            fetch_addr_d = branch_target_i;
        end else if (gnt_fire) begin
            fetch_addr_d = next_fetch_addr(fetch_addr_q);
        end

        rsp_addr_d = rsp_addr_q;
        if (pc_set_i) begin
            rsp_addr_d = branch_target_i;
        end else if (push) begin
            rsp_addr_d = next_fetch_addr(rsp_addr_q);
        end

        presented_d = pc_set_i ? 1'b0 : (instr_valid_id_o & ~pop);

        // Reserve a buffer slot for every response still in flight, dropped ones included.
        issue_next = req_i
                     && ((32'(outstanding_d) + 32'(count_next)) < FIFO_DEPTH)
                     && (32'(outstanding_d) < MAX_OUTSTANDING);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue_next) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (pc_set_i || gnt_fire) begin
                    state_d = issue_next ? StReq : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instr_req_o = 1'b0;
        unique case (state_q)
            StIdle:  instr_req_o = 1'b0;
            StReq:   instr_req_o = 1'b1;
            default: instr_req_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q  <= boot_addr_i;
            rsp_addr_q    <= boot_addr_i;
            outstanding_q <= '0;
            discard_q     <= '0;
            presented_q   <= 1'b0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            rsp_addr_q    <= rsp_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            presented_q   <= presented_d;
        end
    end

    assign instr_addr_o     = fetch_addr_q;
    assign instr_valid_id_o = ~fifo_empty;
    assign instr_new_id_o   = instr_valid_id_o & ~presented_q;
    assign instr_rdata_id_o = head.rdata;
    assign pc_id_o          = head.pc;
    assign busy_o           = instr_req_o | (outstanding_q != '0);

`ifdef IBEX_PREFETCH_FETCH_ERR_EN
    assign instr_fetch_err_o = head.err;
`else
    logic unused_err;
    assign unused_err        = instr_err_i;
    assign instr_fetch_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_if_prefetch.sv
// Directed bench for ibex_if_prefetch: boot, backpressure, redirect, wrap, fetch errors, reset.
// Expected fetch error depends on IBEX_PREFETCH_FETCH_ERR_EN.
module tb_ibex_if_prefetch;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] boot_addr_i = 32'h0000_0080;
    logic        pc_set_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_err_i = 1'b0;
    logic        instr_valid_id_o;
    logic        instr_new_id_o;
    logic [31:0] instr_rdata_id_o;
    logic [31:0] pc_id_o;
    logic        instr_fetch_err_o;
    logic        id_in_ready_i = 1'b0;
    logic        instr_valid_clear_i = 1'b0;
    logic        busy_o;

`ifdef IBEX_PREFETCH_FETCH_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    bit          gnt_auto = 1'b0;
    bit          rsp_hold = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic [31:0] mem_a;
    logic [31:0] gnt_log[$];
    logic [31:0] pend[$];
    logic [31:0] pc_log[$];
    int          outst = 0;
    int          max_outst = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          mk, pk, k;

    ibex_if_prefetch dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .req_i              (req_i),
        .boot_addr_i        (boot_addr_i),
        .pc_set_i           (pc_set_i),
        .branch_target_i    (branch_target_i),
        .instr_req_o        (instr_req_o),
        .instr_addr_o       (instr_addr_o),
        .instr_gnt_i        (instr_gnt_i),
        .instr_rvalid_i     (instr_rvalid_i),
        .instr_rdata_i      (instr_rdata_i),
        .instr_err_i        (instr_err_i),
        .instr_valid_id_o   (instr_valid_id_o),
        .instr_new_id_o     (instr_new_id_o),
        .instr_rdata_id_o   (instr_rdata_id_o),
        .pc_id_o            (pc_id_o),
        .instr_fetch_err_o  (instr_fetch_err_o),
        .id_in_ready_i      (id_in_ready_i),
        .instr_valid_clear_i(instr_valid_clear_i),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    // Bus monitor: grants, outstanding count and every entry presented to ID.
    always @(negedge clk) begin
        if (instr_req_o && instr_gnt_i) begin
            gnt_log.push_back(instr_addr_o);
            pend.push_back(instr_addr_o);
            outst++;
        end
        if (instr_rvalid_i) outst--;
        if (outst > max_outst) max_outst = outst;
        if (instr_valid_id_o && instr_new_id_o) pc_log.push_back(pc_id_o);
    end

    // Memory: answers each grant one cycle later unless responses are held.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            instr_gnt_i = gnt_auto;
            if (!rsp_hold && pend.size() > 0) begin
                mem_a          = pend.pop_front();
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_a ^ 32'hC0DE_0000;
                instr_err_i    = err_en && (mem_a == err_addr);
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = '0;
                instr_err_i    = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, instr_req_o, 1'b0);
        check_eq({tag, "_addr"}, instr_addr_o, 32'h0000_0080);
        check_eq({tag, "_valid"}, instr_valid_id_o, 1'b0);
        check_eq({tag, "_new"}, instr_new_id_o, 1'b0);
        check_eq({tag, "_rdata"}, instr_rdata_id_o, 32'h0);
        check_eq({tag, "_pc"}, pc_id_o, 32'h0);
        check_eq({tag, "_err"}, instr_fetch_err_o, 1'b0);
        check_eq({tag, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("rst0");
        req_i    = 1'b1;
        gnt_auto = 1'b1;
        step(2);
        check_eq("rst0_hold_req", instr_req_o, 1'b0);
        rst_ni = 1'b1;

        // Boot from 0x80 with immediate grant and one-cycle response.
        k = 0;
        while (!instr_rvalid_i && k < 20) begin
            step(1);
            k++;
        end
        check_eq("boot_rvalid_seen", instr_rvalid_i, 1'b1);
        check_eq("boot_valid_early", instr_valid_id_o, 1'b0);
        step(1);
        check_eq("boot_valid", instr_valid_id_o, 1'b1);
        check_eq("boot_pc", pc_id_o, 32'h0000_0080);
        check_eq("boot_rdata", instr_rdata_id_o, 32'hC0DE_0080);
        check_eq("boot_new", instr_new_id_o, 1'b1);
        step(1);
        check_eq("boot_new_once", instr_new_id_o, 1'b0);
        check_eq("boot_pc_hold", pc_id_o, 32'h0000_0080);

        // Backpressure: ID stalled, buffer full, no further requests.
        step(10);
        check_eq("bp_gnt_count", gnt_log.size(), 2);
        check_eq("bp_gnt0", gnt_log[0], 32'h0000_0080);
        check_eq("bp_gnt1", gnt_log[1], 32'h0000_0084);
        check_eq("bp_req_off", instr_req_o, 1'b0);
        check_eq("bp_busy", busy_o, 1'b0);
        check_eq("bp_head", pc_id_o, 32'h0000_0080);
        check_eq("bp_max_outst", max_outst <= 2, 1'b1);
        id_in_ready_i = 1'b1;
        step(1);
        id_in_ready_i = 1'b0;
        check_eq("bp_pop_pc", pc_id_o, 32'h0000_0084);
        check_eq("bp_pop_new", instr_new_id_o, 1'b1);
        check_eq("bp_pop_req", instr_req_o, 1'b1);
        check_eq("bp_pop_addr", instr_addr_o, 32'h0000_0088);

        // Redirect with two responses in flight.
        rsp_hold      = 1'b1;
        id_in_ready_i = 1'b1;
        step(8);
        check_eq("rd_gnt_count", gnt_log.size(), 4);
        check_eq("rd_gnt2", gnt_log[2], 32'h0000_0088);
        check_eq("rd_gnt3", gnt_log[3], 32'h0000_008C);
        check_eq("rd_req_off", instr_req_o, 1'b0);
        check_eq("rd_empty", instr_valid_id_o, 1'b0);
        check_eq("rd_busy", busy_o, 1'b1);
        pc_set_i        = 1'b1;
        branch_target_i = 32'h0000_1000;
        step(1);
        pc_set_i = 1'b0;
        check_eq("rd_addr_next", instr_addr_o, 32'h0000_1000);
        check_eq("rd_req_blocked", instr_req_o, 1'b0);
        rsp_hold = 1'b0;
        k = 0;
        while (!instr_valid_id_o && k < 30) begin
            step(1);
            k++;
        end
        check_eq("rd_valid_seen", instr_valid_id_o, 1'b1);
        check_eq("rd_first_pc", pc_id_o, 32'h0000_1000);
        check_eq("rd_first_rdata", instr_rdata_id_o, 32'hC0DE_1000);
        check_eq("rd_gnt4", gnt_log[4], 32'h0000_1000);

        // Ungranted request held stable, then redirected to the last word.
        gnt_auto = 1'b0;
        step(4);
        mk = gnt_log.size();
        check_eq("hold_req0", instr_req_o, 1'b1);
        step(2);
        check_eq("hold_req1", instr_req_o, 1'b1);
        check_eq("hold_no_gnt", gnt_log.size(), mk);
        pk              = pc_log.size();
        pc_set_i        = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        gnt_auto        = 1'b1;
        step(1);
        pc_set_i = 1'b0;
        check_eq("wrap_addr_ungranted", instr_addr_o, 32'hFFFF_FFFC);
        check_eq("wrap_req", instr_req_o, 1'b1);
        step(8);
        check_eq("wrap_gnt0", gnt_log[mk], 32'hFFFF_FFFC);
        check_eq("wrap_gnt1", gnt_log[mk+1], 32'h0000_0000);
        check_eq("wrap_pc0", pc_log[pk], 32'hFFFF_FFFC);
        check_eq("wrap_pc1", pc_log[pk+1], 32'h0000_0000);

        // Bus error on the second response after a redirect to 0x200.
        err_en          = 1'b1;
        err_addr        = 32'h0000_0204;
        id_in_ready_i   = 1'b0;
        pc_set_i        = 1'b1;
        branch_target_i = 32'h0000_0200;
        step(1);
        pc_set_i = 1'b0;
        step(8);
        check_eq("err_valid0", instr_valid_id_o, 1'b1);
        check_eq("err_pc0", pc_id_o, 32'h0000_0200);
        check_eq("err_rdata0", instr_rdata_id_o, 32'hC0DE_0200);
        check_eq("err_flag0", instr_fetch_err_o, 1'b0);
        check_eq("err_req_full", instr_req_o, 1'b0);
        id_in_ready_i = 1'b1;
        step(1);
        id_in_ready_i = 1'b0;
        check_eq("err_pc1", pc_id_o, 32'h0000_0204);
        check_eq("err_new1", instr_new_id_o, 1'b1);
        check_eq("err_flag1", instr_fetch_err_o, ERR_EXP);
        id_in_ready_i = 1'b1;
        step(1);
        id_in_ready_i = 1'b0;
        step(3);
        check_eq("err_valid2", instr_valid_id_o, 1'b1);
        check_eq("err_pc2", pc_id_o, 32'h0000_0208);
        check_eq("err_flag2", instr_fetch_err_o, 1'b0);

        // Reset with one response in flight, delivered after reset release.
        err_en        = 1'b0;
        id_in_ready_i = 1'b1;
        gnt_auto      = 1'b0;
        rsp_hold      = 1'b1;
        step(6);
        check_eq("mr_req_pending", instr_req_o, 1'b1);
        mk       = gnt_log.size();
        gnt_auto = 1'b1;
        step(1);
        gnt_auto = 1'b0;
        step(1);
        check_eq("mr_one_gnt", gnt_log.size(), mk + 1);
        check_eq("mr_gnt_addr", gnt_log[mk], 32'h0000_0210);
        check_eq("mr_busy", busy_o, 1'b1);
        req_i  = 1'b0;
        rst_ni = 1'b0;
        #1 check_reset_outputs("mr_in_rst");
        step(2);
        rst_ni   = 1'b1;
        rsp_hold = 1'b0;
        pk       = pc_log.size();
        step(4);
        check_reset_outputs("mr_after");
        check_eq("mr_no_entry", pc_log.size(), pk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 0, 1);
        $fatal(1);
    end

endmodule

// File: doc/ibex_if_prefetch.md
IBEX_IF_PREFETCH -- requirements
Module: ibex_if_prefetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries, legal values 2..4.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2: maximum memory requests that are granted but not yet responded.
REQ-003 SHALL have clk_i input 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni input 1: asynchronous reset, active low.
REQ-005 SHALL have req_i input 1: core fetch enable.
REQ-006 SHALL have boot_addr_i input 32: first fetch address after reset.
REQ-007 SHALL have pc_set_i input 1: redirect request.
REQ-008 SHALL have branch_target_i input 32: redirect address, word-aligned.
REQ-009 SHALL have instr_req_o output 1: memory request.
REQ-010 SHALL have instr_addr_o output 32: memory request address.
REQ-011 SHALL have instr_gnt_i input 1: memory request grant.
REQ-012 SHALL have instr_rvalid_i input 1: memory response valid.
REQ-013 SHALL have instr_rdata_i input 32: memory response data.
REQ-014 SHALL have instr_err_i input 1: memory response error.
REQ-015 SHALL have instr_valid_id_o output 1: ID stage data valid.
REQ-016 SHALL have instr_new_id_o output 1: first cycle the current head entry is presented.
REQ-017 SHALL have instr_rdata_id_o output 32: instruction word to ID.
REQ-018 SHALL have pc_id_o output 32: PC of instr_rdata_id_o.
REQ-019 SHALL have instr_fetch_err_o output 1: head entry has a bus error.
REQ-020 SHALL have id_in_ready_i input 1: ID accepts the head entry.
REQ-021 SHALL have instr_valid_clear_i input 1: ID drops the head entry.
REQ-022 SHALL have busy_o output 1: request or response outstanding.

Function
REQ-023 SHALL use FSM IDLE/REQ: IDLE->REQ when req_i and free slots > outstanding and outstanding < MAX_OUTSTANDING; REQ->IDLE on gnt when the issue condition is false next.
REQ-024 SHALL hold instr_req_o and instr_addr_o stable in REQ until instr_gnt_i, except on redirect.
REQ-025 SHALL increment the fetch address by 4 per grant, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-026 SHALL count outstanding: +1 on gnt, -1 on rvalid, both in the same cycle gives net 0.
REQ-027 SHALL write rvalid data/err/PC to the FIFO tail; instr_valid_id_o SHALL rise the cycle after the rvalid (1-cycle latency).
REQ-028 SHALL present the head entry while the FIFO is non-empty; it pops on (instr_valid_id_o & id_in_ready_i) or instr_valid_clear_i.
REQ-029 SHALL pulse instr_new_id_o for exactly one cycle per entry, when it first becomes head.
REQ-030 SHALL allow a push and a pop in the same cycle when full; never overflow, because issue is gated by free slots.
REQ-031 SHALL, on pc_set_i: flush the FIFO next cycle; load the discard counter with outstanding minus any same-cycle rvalid; and set the fetch address to branch_target_i, with instr_addr_o showing the target in cycle N+1 even if the old request was ungranted.
REQ-032 SHALL drop responses while the discard counter is nonzero (decrement per rvalid); these responses are never written.
REQ-033 SHALL give pc_set_i priority over a simultaneous pop and push.
REQ-034 SHALL drive busy_o = instr_req_o | (outstanding != 0).

Reset
REQ-035 SHALL on rst_ni low asynchronously reset: FSM=IDLE; FIFO empty; counters 0; fetch address=boot_addr_i.
REQ-036 SHALL drive all outputs 0 while in reset, except instr_addr_o=boot_addr_i.
REQ-037 SHALL discard in-flight responses arriving after a mid-operation reset (outstanding reset to 0).

Configuration
REQ-038 SHALL, with IBEX_PREFETCH_FETCH_ERR_EN defined, store instr_err_i per entry and drive instr_fetch_err_o from the head entry.
REQ-039 SHALL, without IBEX_PREFETCH_FETCH_ERR_EN, tie instr_fetch_err_o to 0, ignore instr_err_i and store no error bit.

Structure
REQ-040 SHALL place the IDLE/REQ state enum, and the 4-byte fetch increment constant, in shared package ibex_pkg.
REQ-041 SHALL implement the buffer as sub-module ibex_fetch_fifo: push, pop, flush, full, empty and head fields.

Verification
REQ-042 SHALL test boot: boot_addr_i=0x80, req_i=1, gnt immediate, rvalid 1 cycle later -> addresses 0x80,0x84; instr_valid_id_o 1 cycle after the first rvalid with pc_id_o=0x80.
REQ-043 SHALL test backpressure: id_in_ready_i=0 for 10 cycles -> FIFO holds 2 entries; at most 2 outstanding; no further req_o once full.
REQ-044 SHALL test redirect: pc_set_i with branch_target_i=0x1000 and 2 outstanding -> both old responses dropped; next instr_valid_id_o has pc_id_o=0x1000.
REQ-045 SHALL test wrap: fetch from 0xFFFFFFFC -> next instr_addr_o=0x00000000.
REQ-046 SHALL test errors: instr_err_i=1 on the 2nd response -> instr_fetch_err_o=1 only while that entry is head (macro on); always 0 (macro off).
REQ-047 SHALL test reset: rst_ni low with 1 outstanding, then a late rvalid -> no valid entry; outputs at reset values.
